// File: rtl/array_1d_row_packer.sv
// rtl/array_1d_row_packer.sv - packs a stream of elements into flat row vectors, column 0 in LSBs
module array_1d_row_packer #(
   parameter int BIT_WIDTH = 4,
   parameter int COLS      = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [BIT_WIDTH-1:0]           in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [COLS*BIT_WIDTH-1:0]      out_data,
   output logic [$clog2(COLS+1)-1:0]      out_cols,
   output logic                           out_valid,
   input  logic                           out_ready
);

   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int OCW = $clog2(COLS + 1);
   localparam int DW  = COLS * BIT_WIDTH;
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   typedef enum logic {ST_FILL, ST_FULL} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [DW-1:0]   data_q, data_d;
   logic [OCW-1:0]  cols_q, cols_d;
   logic            in_xfer;
   logic            out_xfer;

   // One buffer serves both as the row under construction and the presented row;
   // it only changes in FULL when the row is handed off, so out_data is stable while stalled.
   assign out_data  = data_q;
   assign out_cols  = cols_q;
   assign out_valid = (state_q == ST_FULL);
   assign in_ready  = (state_q == ST_FILL) ? 1'b1 : out_ready;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = (state_q == ST_FULL) & out_ready;

   // Next-state: column writes, row close, hand-off with optional overlapping first element
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      data_d  = data_q;
      cols_d  = cols_q;
      case (state_q)
         ST_FILL: begin
            if (in_xfer) begin
               data_d[col_q*BIT_WIDTH +: BIT_WIDTH] = in_data;
               if ((col_q == COL_MAX) || in_last) begin
                  state_d = ST_FULL;
                  cols_d  = OCW'(col_q) + OCW'(1);
                  col_d   = '0;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               // Clearing here gives zero padding for any row that later closes early.
               data_d  = '0;
               col_d   = '0;
               state_d = ST_FILL;
               if (in_xfer) begin
                  data_d[BIT_WIDTH-1:0] = in_data;
                  if (in_last || (COLS == 1)) begin
                     state_d = ST_FULL;
                     cols_d  = OCW'(1);
                  end else begin
                     col_d = CW'(1);
                  end
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // State register with asynchronous clear; a partial row is simply dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         col_q   <= '0;
         data_q  <= '0;
         cols_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         data_q  <= data_d;
         cols_q  <= cols_d;
      end
   end

endmodule

// File: tb/tb_array_1d_row_packer.sv
// tb/tb_array_1d_row_packer.sv - scoreboard bench for array_1d_row_packer
module tb_array_1d_row_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_cols;
   logic        out_valid;
   logic        out_ready;

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;
   logic [35:0] exp_q[$];
   logic [35:0] mon_e;

   array_1d_row_packer #(.BIT_WIDTH(4), .COLS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_cols(out_cols), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_row(input logic [31:0] d, input logic [3:0] c);
      exp_q.push_back({c, d});
   endtask

   // Present one element and hold it until accepted (bounded)
   task automatic send(input logic [3:0] d, input logic last);
      int waited;
      waited   = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         stalls++;
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
      end else begin
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every output transfer is compared against the oldest expected row
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_row: got %h cols %0d expected no row", out_data, out_cols);
         end else begin
            mon_e = exp_q.pop_front();
            chk("row_data", out_data, mon_e[31:0]);
            chk("row_cols", {28'b0, out_cols}, {28'b0, mon_e[35:32]});
         end
      end
   end

   initial begin
      int w;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_out_cols", {28'b0, out_cols}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      idle(2);

      // Full row back-to-back, one-cycle latency
      stalls = 0;
      push_row(32'h87654321, 4'd8);
      for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
      chk("t1_latency_valid", {31'b0, out_valid}, 32'd1);
      chk("t1_no_stall", stalls, 0);
      idle(2);

      // Early termination with padding, then a full row showing no stale data
      push_row(32'h00000CBA, 4'd3);
      send(4'hA, 1'b0);
      send(4'hB, 1'b0);
      send(4'hC, 1'b1);
      push_row(32'hFFFFFFFF, 4'd8);
      for (int i = 0; i < 8; i++) send(4'hF, 1'b0);
      idle(2);

      // Backpressure: row held stable, pending element not lost
      out_ready = 1'b0;
      push_row(32'h87654321, 4'd8);
      for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
      in_data  = 4'h9;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
         chk("t3_data_stable", out_data, 32'h87654321);
         chk("t3_valid_held", {31'b0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_row(32'h0FEDCBA9, 4'd8);
      send(4'h9, 1'b0);
      chk("t3_overlap_fill", {31'b0, out_valid}, 32'd0);
      chk("t3_col0_written", {28'b0, out_data[3:0]}, 32'h9);
      for (int i = 10; i <= 16; i++) send(4'(i), 1'b0);
      idle(2);

      // 24 elements with random idle gaps
      push_row(32'h76543210, 4'd8);
      push_row(32'hFEDCBA98, 4'd8);
      push_row(32'h76543210, 4'd8);
      for (int i = 0; i < 24; i++) begin
         idle($urandom_range(0, 2));
         send(4'(i), 1'b0);
      end
      idle(3);

      // Reset mid-row discards the partial row
      for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
      rst_n = 1'b0;
      idle(2);
      @(negedge clk);
      chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("t5_rst_data", out_data, 32'd0);
      rst_n = 1'b1;
      idle(1);
      push_row(32'h87654321, 4'd8);
      for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
      idle(2);

      // Single-element rows, second one overlaps the hand-off and stays FULL
      push_row(32'h00000005, 4'd1);
      send(4'h5, 1'b1);
      push_row(32'h00000006, 4'd1);
      send(4'h6, 1'b1);
      chk("t6_stay_full", {31'b0, out_valid}, 32'd1);
      chk("t6_data", out_data, 32'h00000006);
      chk("t6_cols", {28'b0, out_cols}, 32'd1);

      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         @(posedge clk);
         w++;
      end
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_1d_row_packer.md
Name: array_1d_row_packer

Overview:
- Streaming packer that collects BIT_WIDTH-wide elements, one per handshake, into a flat COLS*BIT_WIDTH row vector.
- Element 0 of a row lands in the least-significant slice, i.e. column 0 at bits [BIT_WIDTH-1:0], column i at bits [(i+1)*BIT_WIDTH-1 -: BIT_WIDTH].
- Sits directly upstream of the 1D-to-2D array converter, producing the flat vector it unpacks.
- Supports early row termination with zero padding.

Parameters:
BIT_WIDTH, 4, width of one element
COLS, 8, elements per row (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  BIT_WIDTH  element to pack
in_valid  input  1  in_data valid
in_last  input  1  qualifies in_valid; element ends the current row early
in_ready  output  1  packer accepts in_data this cycle
out_data  output  COLS*BIT_WIDTH  packed row, column 0 in LSBs
out_cols  output  $clog2(COLS+1)  number of real (non-padded) columns in out_data, 1..COLS
out_valid  output  1  out_data/out_cols valid
out_ready  input  1  downstream accepts row

Behaviour:
- Reset (async assert, sync deassert by user):
  - out_valid=0, out_data=0, out_cols=0.
  - Internal column counter col=0, state FILL.
- Handshakes:
  - Input transfer = in_valid&in_ready.
  - Output transfer = out_valid&out_ready.
  - out_data/out_cols/out_valid stable while out_valid=1 and out_ready=0.
- States:
  - FILL: out_valid=0, in_ready=1.
    - On input transfer, write in_data to slice col.
    - If col==COLS-1 or in_last=1: go to FULL next cycle, set out_cols=col+1, out_valid=1, col=0.
    - Otherwise col increments.
  - FULL: out_valid=1, in_ready=out_ready (combinational pass-through; no other comb path input->output).
    - On output transfer without input transfer: go to FILL, col=0.
    - On simultaneous output and input transfer: the element is written to slice 0 of the next row, col=1, state FILL, out_valid=0 next cycle.
    - If that element has in_last=1 or COLS==1: stay FULL with out_cols=1.
- Zero padding:
  - On entry to FILL from FULL, and on reset, all slices are cleared, so columns >= out_cols read 0 when a row closes early via in_last.
  - The clear and the slice-0 write in the simultaneous case happen in the same cycle; the written element wins in slice 0.
- Latency: the last element of a row is accepted in cycle N; out_valid=1 in cycle N+1.
- Throughput: one element per cycle sustained when out_ready=1; no bubble between rows.
- in_valid=0 in FILL: no state change, col holds.
- in_last ignored when in_valid=0.
- Reset mid-row: partial row discarded, no output produced.
- Counter width $clog2(COLS); col never exceeds COLS-1.

Test Plan:
- BIT_WIDTH=4, COLS=8, out_ready=1, feed 0x1..0x8 back-to-back -> one cycle after 0x8 accepted, out_valid=1, out_data=0x87654321, out_cols=8, in_ready never drops.
- Feed 0xA,0xB,0xC with in_last on 0xC -> out_data=0x00000CBA, out_cols=3; next row, 8 elements of 0xF -> out_data=0xFFFFFFFF (no stale data).
- Complete row 0x1..0x8, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stays 0x87654321, no element lost; raise out_ready -> 0x9 accepted same cycle into column 0 of next row.
- Stream 24 elements 0x0..0xF,0x0..0x7 with random in_valid gaps, out_ready=1 -> rows 0x76543210, 0xFEDCBA98, 0x76543210, each out_cols=8.
- Assert rst_n=0 after 4 elements accepted, release, feed 0x1..0x8 -> single output 0x87654321; no output from the partial row.
- in_last on first element 0x5 -> out_data=0x00000005, out_cols=1; with out_ready=1 and another in_last element 0x6 in the same cycle -> state stays FULL, next out_data=0x00000006, out_cols=1.
